// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle processor control unit.
//   state_t        : controller states (also the state_o debug encoding)
//   OP_*           : instruction opcodes
//   ALU_*          : alu_op codes
//   SRCB_*         : alu_src_b select codes
//   is_wait_state(): states that wait on mem_ready and can time out
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b111;
  localparam logic [2:0] OP_LW    = 3'b000;
  localparam logic [2:0] OP_SW    = 3'b001;
  localparam logic [2:0] OP_BEQ   = 3'b011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  function automatic logic is_wait_state(input state_t s);
    return s inside {FETCH, MEM_RD, MEM_WR};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer for multicycle_ctrl.
//   clk, rst   : clock and synchronous active-high reset
//   active     : controller is in a state waiting on mem_ready
//   mem_ready  : memory completion
//   timeout    : this cycle is the MEM_WAIT_MAX-th consecutive wait cycle
//                and mem_ready is still low
// The counter holds the number of wait cycles already spent in the current
// memory state. It is cleared whenever the controller is outside a wait
// state or the access completes, so every wait state is entered with 0.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] wait_cnt;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || !active || mem_ready) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // mem_ready has priority: a completing access never times out.
  assign timeout = active && !mem_ready && (wait_cnt == 8'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit (R-type and/or, lw, sw, beq).
//   clk, rst        : clock, synchronous active-high reset
//   opcode          : instruction opcode from the IR
//   zero            : ALU zero flag (used in BRANCH)
//   mem_ready       : memory completion for the current read/write
//   pc_write, ir_write, i_or_d, mem_read, mem_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src
//                   : datapath controls decoded from the state register
//   fault           : sticky; illegal opcode or memory timeout
//   state_o         : current state encoding for debug
//   instr_cnt       : retired-instruction count, present only when the
//                     macro CTRL_PERF_CNT_EN is defined
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_src,
  output logic        fault,
  output logic [3:0]  state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0] instr_cnt
`endif
);

  state_t state;
  logic   timeout;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .active   (is_wait_state(state)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // Every transition into TRAP also raises the sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      fault <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ready)    state <= DECODE;
          else if (timeout) begin state <= TRAP; fault <= 1'b1; end
        end
        DECODE: begin
          unique case (opcode)
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_RTYPE:     state <= R_EXEC;
            OP_BEQ:       state <= BRANCH;
            default:      begin state <= TRAP; fault <= 1'b1; end
          endcase
        end
        MEM_ADDR: begin
          if (opcode == OP_LW)      state <= MEM_RD;
          else if (opcode == OP_SW) state <= MEM_WR;
          else                      begin state <= TRAP; fault <= 1'b1; end
        end
        MEM_RD: begin
          if (mem_ready)    state <= MEM_WB;
          else if (timeout) begin state <= TRAP; fault <= 1'b1; end
        end
        MEM_WR: begin
          if (mem_ready)    state <= FETCH;
          else if (timeout) begin state <= TRAP; fault <= 1'b1; end
        end
        MEM_WB, R_WB, BRANCH: state <= FETCH;
        R_EXEC:               state <= R_WB;
        TRAP:                 state <= TRAP;
        default:              begin state <= TRAP; fault <= 1'b1; end
      endcase
    end
  end

  assign state_o = state;

  // Write strobes are forced low while rst is asserted so a reset taken
  // mid-access never commits a write.
  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    pc_src     = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready && !rst;
        pc_write  = mem_ready && !rst;
      end
      DECODE:   alu_src_b = SRCB_BOFF;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = !rst;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = !rst;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write = !rst;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = zero && !rst;
      end
      default: ;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  // One instruction retires on each return to FETCH from a final state.
  logic retire;
  assign retire = (state inside {MEM_WB, R_WB, BRANCH}) ||
                  (state == MEM_WR && mem_ready);

  always_ff @(posedge clk) begin
    if (rst)         instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 16'd1;
  end
`endif

endmodule
